// File: rtl/cpu_execute_hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_execute_hazard_ctrl_if : decode/EX/commit/writeback hazard signal bundle |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
interface cpu_execute_hazard_ctrl_if #(
  parameter int REG_ID_W = 5,
  parameter int CNT_W    = 32
);
  logic                dec_valid;
  logic [REG_ID_W-1:0] dec_ra_id;
  logic [REG_ID_W-1:0] dec_rb_id;
  logic                dec_use_rb;
  logic                dec_mem_read;
  logic                dec_reg_write;
  logic [REG_ID_W-1:0] dec_reg_dest;
  logic [REG_ID_W-1:0] ex_ra_id;
  logic [REG_ID_W-1:0] ex_rb_id;
  logic                cm_reg_write;
  logic [REG_ID_W-1:0] cm_reg_dest;
  logic                wb_reg_write;
  logic [REG_ID_W-1:0] wb_reg_dest;
  logic                branch_taken;
  logic                cache_stall;
  logic                if_id_stall;
  logic                if_id_flush;
  logic                id_ex_bubble;
  logic                ex_stall;
  logic [1:0]          fwd_a_sel;
  logic [1:0]          fwd_b_sel;
  logic [CNT_W-1:0]    stall_cycles;

  modport master (
    output dec_valid, dec_ra_id, dec_rb_id, dec_use_rb, dec_mem_read,
           dec_reg_write, dec_reg_dest, ex_ra_id, ex_rb_id, cm_reg_write,
           cm_reg_dest, wb_reg_write, wb_reg_dest, branch_taken, cache_stall,
    input  if_id_stall, if_id_flush, id_ex_bubble, ex_stall, fwd_a_sel,
           fwd_b_sel, stall_cycles
  );

  modport slave (
    input  dec_valid, dec_ra_id, dec_rb_id, dec_use_rb, dec_mem_read,
           dec_reg_write, dec_reg_dest, ex_ra_id, ex_rb_id, cm_reg_write,
           cm_reg_dest, wb_reg_write, wb_reg_dest, branch_taken, cache_stall,
    output if_id_stall, if_id_flush, id_ex_bubble, ex_stall, fwd_a_sel,
           fwd_b_sel, stall_cycles
  );
endinterface
`default_nettype wire

// File: rtl/cpu_execute_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_execute_hazard_ctrl : load-use/branch/cache stall sequencing, forwarding |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module cpu_execute_hazard_ctrl #(
  parameter int REG_ID_W = 5,
  parameter int CNT_W    = 32
) (
  input  wire logic                clock_i,
  input  wire logic                reset_i,
  cpu_execute_hazard_ctrl_if.slave hz
);
  typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                flush_pend_q, flush_pend_d;
  logic                ex_valid_q, ex_mem_read_q, ex_reg_write_q;
  logic [REG_ID_W-1:0] ex_reg_dest_q;
  logic [CNT_W-1:0]    stall_cnt_q;

  logic                hazard;
  logic                if_id_stall, if_id_flush, id_ex_bubble, ex_stall;
  logic [1:0]          fwd_a_sel, fwd_b_sel;

  assign hazard = hz.dec_valid & ex_valid_q & ex_mem_read_q & ex_reg_write_q
                & (ex_reg_dest_q != '0)
                & ((ex_reg_dest_q == hz.dec_ra_id)
                   | (hz.dec_use_rb & (ex_reg_dest_q == hz.dec_rb_id)));

  // The release cycle of MEM_WAIT falls through to the RUN evaluation below.
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_stall     = 1'b0;
    if (!reset_i) begin
      if (hz.cache_stall) begin
        state_d     = MEM_WAIT;
        ex_stall    = 1'b1;
        if_id_stall = 1'b1;
        if (state_q == RUN && hz.branch_taken) begin
          flush_pend_d = 1'b1;
        end
      end else begin
        state_d = RUN;
        if (hz.branch_taken || flush_pend_q) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          flush_pend_d = 1'b0;
        end else if (hazard) begin
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
        end
      end
    end
  end

  // Register id 0 is hard-wired zero, so it never forwards.
  always_comb begin
    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
    if (!reset_i && hz.ex_ra_id != '0) begin
      if (hz.cm_reg_write && hz.cm_reg_dest == hz.ex_ra_id) begin
        fwd_a_sel = 2'd1;
      end else if (hz.wb_reg_write && hz.wb_reg_dest == hz.ex_ra_id) begin
        fwd_a_sel = 2'd2;
      end
    end
    if (!reset_i && hz.ex_rb_id != '0) begin
      if (hz.cm_reg_write && hz.cm_reg_dest == hz.ex_rb_id) begin
        fwd_b_sel = 2'd1;
      end else if (hz.wb_reg_write && hz.wb_reg_dest == hz.ex_rb_id) begin
        fwd_b_sel = 2'd2;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= RUN;
      flush_pend_q   <= 1'b0;
      ex_valid_q     <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_reg_dest_q  <= '0;
      stall_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      if (!hz.cache_stall) begin
        if (id_ex_bubble || if_id_flush) begin
          ex_valid_q     <= 1'b0;
          ex_mem_read_q  <= 1'b0;
          ex_reg_write_q <= 1'b0;
          ex_reg_dest_q  <= '0;
        end else begin
          ex_valid_q     <= hz.dec_valid;
          ex_mem_read_q  <= hz.dec_mem_read;
          ex_reg_write_q <= hz.dec_reg_write;
          ex_reg_dest_q  <= hz.dec_reg_dest;
        end
      end
      if (if_id_stall && stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hz.if_id_stall  = if_id_stall;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.ex_stall     = ex_stall;
  assign hz.fwd_a_sel    = fwd_a_sel;
  assign hz.fwd_b_sel    = fwd_b_sel;
  assign hz.stall_cycles = stall_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_cpu_execute_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cpu_execute_hazard_ctrl : directed vector bench for the hazard control   |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_cpu_execute_hazard_ctrl;
  localparam int REG_ID_W = 5;
  localparam int CNT_W    = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  cpu_execute_hazard_ctrl_if #(.REG_ID_W(REG_ID_W), .CNT_W(CNT_W)) hz ();

  cpu_execute_hazard_ctrl #(.REG_ID_W(REG_ID_W), .CNT_W(CNT_W)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .hz      (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       branch;
    logic       cm_w;
    logic [4:0] cm_d;
    logic       wb_w;
    logic [4:0] wb_d;
    logic [4:0] ex_ra;
    logic [4:0] ex_rb;
    logic [7:0] exp_out;
  } vec_t;

  // {flush, bubble, if_id_stall, ex_stall, fwd_a[1:0], fwd_b[1:0]}
  function automatic logic [7:0] outs();
    return {hz.if_id_flush, hz.id_ex_bubble, hz.if_id_stall, hz.ex_stall,
            hz.fwd_a_sel, hz.fwd_b_sel};
  endfunction

  function automatic logic [7:0] ctl(input logic fl, input logic bu,
                                     input logic st, input logic es);
    return {fl, bu, st, es, 4'b0000};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    hz.dec_valid     = 1'b0;
    hz.dec_ra_id     = '0;
    hz.dec_rb_id     = '0;
    hz.dec_use_rb    = 1'b0;
    hz.dec_mem_read  = 1'b0;
    hz.dec_reg_write = 1'b0;
    hz.dec_reg_dest  = '0;
    hz.ex_ra_id      = '0;
    hz.ex_rb_id      = '0;
    hz.cm_reg_write  = 1'b0;
    hz.cm_reg_dest   = '0;
    hz.wb_reg_write  = 1'b0;
    hz.wb_reg_dest   = '0;
    hz.branch_taken  = 1'b0;
    hz.cache_stall   = 1'b0;
  endtask

  task automatic dec(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                     input logic use_rb, input logic ld, input logic wr,
                     input logic [4:0] dst);
    hz.dec_valid     = v;
    hz.dec_ra_id     = ra;
    hz.dec_rb_id     = rb;
    hz.dec_use_rb    = use_rb;
    hz.dec_mem_read  = ld;
    hz.dec_reg_write = wr;
    hz.dec_reg_dest  = dst;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    idle();

    vecs[0] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 5'd0,  5'd0,  8'b0000_0000};
    vecs[1] = '{1'b0, 1'b1, 5'd5,  1'b1, 5'd5, 5'd2,  5'd5,  8'b0000_0001};
    vecs[2] = '{1'b0, 1'b0, 5'd5,  1'b1, 5'd5, 5'd2,  5'd5,  8'b0000_0010};
    vecs[3] = '{1'b0, 1'b1, 5'd0,  1'b1, 5'd0, 5'd0,  5'd0,  8'b0000_0000};
    vecs[4] = '{1'b0, 1'b1, 5'd7,  1'b1, 5'd9, 5'd9,  5'd7,  8'b0000_1001};
    vecs[5] = '{1'b0, 1'b1, 5'd31, 1'b0, 5'd0, 5'd31, 5'd31, 8'b0000_0101};
    vecs[6] = '{1'b1, 1'b0, 5'd0,  1'b0, 5'd0, 5'd0,  5'd0,  8'b1100_0000};
    vecs[7] = '{1'b0, 1'b0, 5'd4,  1'b0, 5'd4, 5'd4,  5'd4,  8'b0000_0000};

    // Reset state
    @(negedge clk);
    hz.cache_stall = 1'b1;
    hz.branch_taken = 1'b1;
    #1;
    chk("reset_outs", {24'd0, outs()}, 32'd0);
    chk("reset_cnt", 32'(hz.stall_cycles), 32'd0);
    idle();
    @(negedge clk);
    rst = 1'b0;

    // Forwarding / branch table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle();
      hz.branch_taken = vecs[i].branch;
      hz.cm_reg_write = vecs[i].cm_w;
      hz.cm_reg_dest  = vecs[i].cm_d;
      hz.wb_reg_write = vecs[i].wb_w;
      hz.wb_reg_dest  = vecs[i].wb_d;
      hz.ex_ra_id     = vecs[i].ex_ra;
      hz.ex_rb_id     = vecs[i].ex_rb;
      #1;
      chk($sformatf("table_%0d", i), {24'd0, outs()}, {24'd0, vecs[i].exp_out});
    end

    // Load r3 then dependent add r4 <- r3, r1
    @(negedge clk);
    idle();
    dec(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3);
    #1 chk("lu_load", {24'd0, outs()}, 32'd0);
    @(negedge clk);
    dec(1'b1, 5'd3, 5'd1, 1'b1, 1'b0, 1'b1, 5'd4);
    #1 chk("lu_stall", {24'd0, outs()}, {24'd0, ctl(1'b0, 1'b1, 1'b1, 1'b0)});
    @(negedge clk);
    #1 chk("lu_release", {24'd0, outs()}, 32'd0);
    chk("lu_cnt", 32'(hz.stall_cycles), 32'd1);

    // Load r5, consumer reads it via rb only
    @(negedge clk);
    dec(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5);
    @(negedge clk);
    dec(1'b1, 5'd8, 5'd5, 1'b1, 1'b0, 1'b1, 5'd6);
    #1 chk("lu_rb", {24'd0, outs()}, {24'd0, ctl(1'b0, 1'b1, 1'b1, 1'b0)});
    @(negedge clk);
    dec(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5);
    @(negedge clk);
    dec(1'b1, 5'd8, 5'd5, 1'b0, 1'b0, 1'b1, 5'd6);
    #1 chk("lu_rb_unused", {24'd0, outs()}, 32'd0);

    // Load to r0 never stalls
    @(negedge clk);
    dec(1'b1, 5'd1, 5'd1, 1'b0, 1'b1, 1'b1, 5'd0);
    @(negedge clk);
    dec(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2);
    hz.cm_reg_write = 1'b1;
    hz.cm_reg_dest  = 5'd0;
    hz.ex_ra_id     = 5'd0;
    #1 chk("r0_load", {24'd0, outs()}, 32'd0);

    // Branch concurrent with load-use hazard
    @(negedge clk);
    idle();
    dec(1'b1, 5'd1, 5'd1, 1'b0, 1'b1, 1'b1, 5'd3);
    @(negedge clk);
    dec(1'b1, 5'd3, 5'd1, 1'b1, 1'b0, 1'b1, 5'd4);
    hz.branch_taken = 1'b1;
    #1 chk("br_hazard", {24'd0, outs()}, {24'd0, ctl(1'b1, 1'b1, 1'b0, 1'b0)});

    // Cache stall 4 cycles with branch in first cycle
    pulse_reset();
    hz.cache_stall  = 1'b1;
    hz.branch_taken = 1'b1;
    #1 chk("cs_first", {24'd0, outs()}, {24'd0, ctl(1'b0, 1'b0, 1'b1, 1'b1)});
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      hz.branch_taken = 1'b0;
      #1 chk($sformatf("cs_hold_%0d", i), {24'd0, outs()},
             {24'd0, ctl(1'b0, 1'b0, 1'b1, 1'b1)});
    end
    @(negedge clk);
    hz.cache_stall = 1'b0;
    #1 chk("cs_release", {24'd0, outs()}, {24'd0, ctl(1'b1, 1'b1, 1'b0, 1'b0)});
    chk("cs_cnt", 32'(hz.stall_cycles), 32'd4);
    @(negedge clk);
    #1 chk("cs_after", {24'd0, outs()}, 32'd0);

    // Counter saturation
    @(negedge clk);
    hz.cache_stall = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clk);
    hz.cache_stall = 1'b0;
    #1 chk("sat_release", {24'd0, outs()}, 32'd0);
    chk("sat_cnt", 32'(hz.stall_cycles), 32'd15);

    // Reset asserted during MEM_WAIT
    pulse_reset();
    hz.cache_stall  = 1'b1;
    hz.branch_taken = 1'b1;
    @(negedge clk);
    hz.branch_taken = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rst_mw_outs", {24'd0, outs()}, 32'd0);
    chk("rst_mw_cnt", 32'(hz.stall_cycles), 32'd0);
    @(negedge clk);
    hz.cache_stall = 1'b0;
    rst = 1'b0;
    #1 chk("rst_mw_run", {24'd0, outs()}, 32'd0);
    @(negedge clk);
    #1 chk("rst_mw_nopend", {24'd0, outs()}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
